// File: rtl/phys_step_scheduler_if.sv
// Object-BRAM bus of phys_step_scheduler: read request, 2-cycle read return, write strobe.
// The master side is the scheduler; the slave side is the dual-port object memory.
`ifndef SF
`define SF 16
`endif
`ifndef DF_DEC
`define DF_DEC 8
`endif
`ifndef OBJ_DYN_WIDTH
`define OBJ_DYN_WIDTH (4*`SF)
`endif

interface phys_step_scheduler_if #(
  parameter int NUM_OBJ = 8
);
  localparam int AW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  logic                      rd_en_out;
  logic [AW-1:0]             rd_addr_out;
  logic [`OBJ_DYN_WIDTH-1:0] rd_data_in;
  logic                      wr_en_out;
  logic [AW-1:0]             wr_addr_out;
  logic [`OBJ_DYN_WIDTH-1:0] wr_data_out;

  modport master (
    output rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, wr_data_out,
    input  rd_data_in
  );

  modport slave (
    input  rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, wr_data_out,
    output rd_data_in
  );
endinterface

// File: rtl/phys_step_scheduler.sv
// One physics time step over all object records: read, integrate pos += vel*dt, write back.
// Optional macro PHYS_GRAVITY_EN also applies GRAVITY*dt to vel_y (explicit Euler).
`ifndef SF
`define SF 16
`endif
`ifndef DF_DEC
`define DF_DEC 8
`endif
`ifndef OBJ_DYN_WIDTH
`define OBJ_DYN_WIDTH (4*`SF)
`endif

module phys_step_scheduler #(
  parameter int                     NUM_OBJ = 8,
  parameter logic signed [`SF-1:0]  GRAVITY = 16'sd0
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       start_in,
  input  logic signed [`DF_DEC+1:0]  time_step_in,
  input  logic [NUM_OBJ-1:0]         active_mask_in,
  output logic                       busy_out,
  output logic                       done_out,
  phys_step_scheduler_if.master      bram
);
  localparam int AW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int SF = `SF;
  localparam int DF = `DF_DEC;
  localparam int PW = SF + DF + 2;
  localparam int RW = `OBJ_DYN_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_OBJ - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CALC    = 3'd4,
    ST_WRITE   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [AW-1:0]      idx_r, idx_s;
  logic [NUM_OBJ-1:0] mask_r, mask_s;
  logic signed [DF+1:0] dt_r, dt_s;
  logic               finish_s;
  logic               rd_en_s;
  logic [RW-1:0]      rec_r;
  logic               rd_en_r, wr_en_r, busy_r, done_r;
  logic [AW-1:0]      rd_addr_r, wr_addr_r;
  logic [RW-1:0]      wr_data_r;
  logic signed [SF-1:0] px_s, py_s, vx_s, vy_s, npx_s, npy_s, nvy_s;

  // (rate * dt) >>> DF at full product width, floor rounding, truncated to SF bits.
  function automatic logic [SF-1:0] scaled(input logic signed [SF-1:0] rate,
                                           input logic signed [DF+1:0] dt);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    prod    = $signed({{(PW-SF){rate[SF-1]}}, rate}) * $signed({{SF{dt[DF+1]}}, dt});
    shifted = prod >>> DF;
    return shifted[SF-1:0];
  endfunction

  assign {px_s, py_s, vx_s, vy_s} = rec_r;
  assign npx_s = px_s + scaled(vx_s, dt_r);
  assign npy_s = py_s + scaled(vy_s, dt_r);
`ifdef PHYS_GRAVITY_EN
  assign nvy_s = vy_s - scaled(GRAVITY, dt_r);
`else
  assign nvy_s = vy_s;
  logic unused_gravity_s;
  assign unused_gravity_s = ^GRAVITY;
`endif

  // Next-state and step bookkeeping; a start is refused during the done_out cycle.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    mask_s   = mask_r;
    dt_s     = dt_r;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_in && !done_r) begin
          state_s = ST_ISSUE;
          idx_s   = '0;
          mask_s  = active_mask_in;
          dt_s    = time_step_in;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mask_r[idx_r]) begin
          state_s = ST_WAIT;
        end else if (idx_r == LAST) begin
          state_s  = ST_IDLE;
          finish_s = 1'b1;
        end else begin
          idx_s = idx_r + AW'(1);
        end
      end
      ST_WAIT:    state_s = ST_CAPTURE;
      ST_CAPTURE: state_s = ST_CALC;
      ST_CALC:    state_s = ST_WRITE;
      ST_WRITE: begin
        if (idx_r == LAST) begin
          state_s  = ST_IDLE;
          finish_s = 1'b1;
        end else begin
          state_s = ST_ISSUE;
          idx_s   = idx_r + AW'(1);
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign rd_en_s = (state_s == ST_ISSUE) && mask_s[idx_s];

  // Control state plus outputs registered from the next state so they line up with it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      mask_r    <= '0;
      dt_r      <= '0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      mask_r    <= mask_s;
      dt_r      <= dt_s;
      rd_en_r   <= rd_en_s;
      rd_addr_r <= rd_en_s ? idx_s : '0;
      wr_en_r   <= (state_s == ST_WRITE);
      wr_addr_r <= (state_s == ST_WRITE) ? idx_s : '0;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= finish_s;
    end
  end

  // Record capture (data returns two cycles after the read) and integrated result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rec_r     <= '0;
      wr_data_r <= '0;
    end else begin
      if (state_r == ST_CAPTURE) rec_r <= bram.rd_data_in;
      if (state_r == ST_CALC) wr_data_r <= {npx_s, npy_s, vx_s, nvy_s};
    end
  end

  assign bram.rd_en_out   = rd_en_r;
  assign bram.rd_addr_out = rd_addr_r;
  assign bram.wr_en_out   = wr_en_r;
  assign bram.wr_addr_out = wr_addr_r;
  assign bram.wr_data_out = wr_data_r;
  assign busy_out         = busy_r;
  assign done_out         = done_r;
endmodule
